// File: rtl/msg_port_arbiter.sv
// msg_port_arbiter: shares the FIFO inside port between N_REQ requesters
// (round-robin outbound push, destination-routed inbound pop with drop counting).
module msg_port_arbiter #(
    parameter int W_MSG = 64,
    parameter int N_REQ = 4,
    parameter int W_ID  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_out_rdy,
    input  logic [N_REQ-1:0][W_MSG-1:0] req_out_msg,
    output logic [N_REQ-1:0]            req_out_ack,
    output logic [N_REQ-1:0]            resp_rdy,
    output logic [W_MSG-1:0]            resp_msg,
    input  logic [N_REQ-1:0]            resp_ack,
    output logic                        fifo_out_rdy,
    output logic [W_MSG-1:0]            fifo_out_msg,
    input  logic                        fifo_out_ack,
    input  logic                        fifo_in_rdy,
    input  logic [W_MSG-1:0]            fifo_in_msg,
    output logic                        fifo_in_ack,
    output logic [7:0]                  drop_cnt
);
    localparam int W_RR = N_REQ > 1 ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {O_IDLE, O_WAIT, O_DONE} o_state_t;
    typedef enum logic [1:0] {I_IDLE, I_DELIVER, I_POP} i_state_t;

    o_state_t          o_state, o_next;
    i_state_t          i_state, i_next;
    logic [W_RR-1:0]   rr, rr_next, pick;
    logic              found;
    logic [N_REQ-1:0]  rot;
    logic [N_REQ-1:0]  gnt, gnt_next, req_out_ack_next, resp_rdy_next;
    logic [W_MSG-1:0]  fifo_out_msg_next, resp_msg_next;
    logic              fifo_out_rdy_next, fifo_in_ack_next;
    logic [7:0]        drop_cnt_next;
    logic [W_ID-1:0]   dest;

    // rotate requests so bit 0 is the requester at rr, then take the lowest set bit
    always_comb begin
        rot   = N_REQ'({req_out_rdy, req_out_rdy} >> rr);
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pick  = W_RR'((int'(rr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        o_next            = o_state;
        rr_next           = rr;
        gnt_next          = gnt;
        fifo_out_rdy_next = fifo_out_rdy;
        fifo_out_msg_next = fifo_out_msg;
        req_out_ack_next  = '0;
        case (o_state)
            O_IDLE: if (found) begin
                o_next            = O_WAIT;
                gnt_next          = N_REQ'(1) << pick;
                fifo_out_rdy_next = 1'b1;
                fifo_out_msg_next = req_out_msg[pick];
                rr_next           = W_RR'((int'(pick) + 1) % N_REQ);
            end
            O_WAIT: if (fifo_out_ack) begin
                o_next            = O_DONE;
                fifo_out_rdy_next = 1'b0;
                req_out_ack_next  = gnt;
            end
            default: o_next = O_IDLE;
        endcase
    end

    // resp_rdy is one-hot on the destination, so it doubles as the ack filter
    always_comb begin
        dest             = fifo_in_msg[W_MSG-1 -: W_ID];
        i_next           = i_state;
        resp_rdy_next    = resp_rdy;
        resp_msg_next    = resp_msg;
        fifo_in_ack_next = 1'b0;
        drop_cnt_next    = drop_cnt;
        case (i_state)
            I_IDLE: if (fifo_in_rdy) begin
                resp_msg_next = fifo_in_msg;
                if (int'(dest) < N_REQ) begin
                    resp_rdy_next = N_REQ'(1) << dest;
                    i_next        = I_DELIVER;
                end else begin
                    i_next           = I_POP;
                    fifo_in_ack_next = 1'b1;
                    drop_cnt_next    = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
                end
            end
            I_DELIVER: if (|(resp_ack & resp_rdy)) begin
                resp_rdy_next    = '0;
                fifo_in_ack_next = 1'b1;
                i_next           = I_POP;
            end
            default: i_next = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_state      <= O_IDLE;
            i_state      <= I_IDLE;
            rr           <= '0;
            gnt          <= '0;
            req_out_ack  <= '0;
            fifo_out_rdy <= 1'b0;
            fifo_out_msg <= '0;
            resp_rdy     <= '0;
            resp_msg     <= '0;
            fifo_in_ack  <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            o_state      <= o_next;
            i_state      <= i_next;
            rr           <= rr_next;
            gnt          <= gnt_next;
            req_out_ack  <= req_out_ack_next;
            fifo_out_rdy <= fifo_out_rdy_next;
            fifo_out_msg <= fifo_out_msg_next;
            resp_rdy     <= resp_rdy_next;
            resp_msg     <= resp_msg_next;
            fifo_in_ack  <= fifo_in_ack_next;
            drop_cnt     <= drop_cnt_next;
        end
    end
endmodule

// File: tb/tb_msg_port_arbiter.sv
// tb_msg_port_arbiter: directed and random transactions against a transaction-level
// model of round-robin grant order, routing and drop counting.
module tb_msg_port_arbiter;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_out_rdy = '0;
    logic [3:0][63:0] req_out_msg = '0;
    logic [3:0]      req_out_ack, resp_rdy;
    logic [63:0]     resp_msg, fifo_out_msg;
    logic [3:0]      resp_ack = '0;
    logic            fifo_out_rdy, fifo_in_ack;
    logic            fifo_out_ack = 1'b0, fifo_in_rdy = 1'b0;
    logic [63:0]     fifo_in_msg = '0;
    logic [7:0]      drop_cnt;

    logic [2:0]       req_out_rdy3 = '0, req_out_ack3, resp_rdy3, resp_ack3 = '0;
    logic [2:0][63:0] req_out_msg3 = '0;
    logic [63:0]      resp_msg3, fifo_out_msg3, fifo_in_msg3 = '0;
    logic             fifo_out_rdy3, fifo_in_ack3, fifo_out_ack3 = 1'b0, fifo_in_rdy3 = 1'b0;
    logic [7:0]       drop_cnt3;

    int n_chk = 0, n_fail = 0, rr_m = 0, drops_m = 0;
    logic [3:0] rdy_q = '0;

    always #5 clk = ~clk;

    msg_port_arbiter u4 (
        .clk(clk), .rst(rst), .req_out_rdy(req_out_rdy), .req_out_msg(req_out_msg),
        .req_out_ack(req_out_ack), .resp_rdy(resp_rdy), .resp_msg(resp_msg), .resp_ack(resp_ack),
        .fifo_out_rdy(fifo_out_rdy), .fifo_out_msg(fifo_out_msg), .fifo_out_ack(fifo_out_ack),
        .fifo_in_rdy(fifo_in_rdy), .fifo_in_msg(fifo_in_msg), .fifo_in_ack(fifo_in_ack),
        .drop_cnt(drop_cnt)
    );

    msg_port_arbiter #(.W_MSG(64), .N_REQ(3), .W_ID(2)) u3 (
        .clk(clk), .rst(rst), .req_out_rdy(req_out_rdy3), .req_out_msg(req_out_msg3),
        .req_out_ack(req_out_ack3), .resp_rdy(resp_rdy3), .resp_msg(resp_msg3), .resp_ack(resp_ack3),
        .fifo_out_rdy(fifo_out_rdy3), .fifo_out_msg(fifo_out_msg3), .fifo_out_ack(fifo_out_ack3),
        .fifo_in_rdy(fifo_in_rdy3), .fifo_in_msg(fifo_in_msg3), .fifo_in_ack(fifo_in_ack3),
        .drop_cnt(drop_cnt3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // starts in an outbound-idle cycle with rdy_q nonzero; ends in the cycle after the dead cycle
    task automatic out_txn(input int stall);
        int g;
        logic [63:0] m;
        g = -1;
        for (int i = 0; i < 4; i++)
            if (g < 0 && rdy_q[(rr_m + i) % 4]) g = (rr_m + i) % 4;
        m = req_out_msg[g];
        req_out_rdy = rdy_q;
        tick;
        chk("out_rdy", {63'd0, fifo_out_rdy}, 64'd1);
        chk("out_msg", fifo_out_msg, m);
        req_out_msg[g] = {$urandom, $urandom};
        for (int s = 0; s < stall; s++) begin
            tick;
            chk("stall_rdy", {63'd0, fifo_out_rdy}, 64'd1);
            chk("stall_ack", {60'd0, req_out_ack}, 64'd0);
        end
        tick;
        fifo_out_ack = 1'b1;
        chk("hold_msg", fifo_out_msg, m);
        tick;
        fifo_out_ack = 1'b0;
        chk("req_ack", {60'd0, req_out_ack}, 64'd1 << g);
        chk("out_rdy_low", {63'd0, fifo_out_rdy}, 64'd0);
        tick;
        rdy_q[g] = 1'b0;
        req_out_rdy = rdy_q;
        chk("ack_pulse", {60'd0, req_out_ack}, 64'd0);
        chk("dead_cycle", {63'd0, fifo_out_rdy}, 64'd0);
        rr_m = (g + 1) % 4;
    endtask

    task automatic in_txn(input logic [63:0] msg, input int delay, input logic [3:0] wrong);
        int d;
        d = int'(msg[63:62]);
        fifo_in_rdy = 1'b1;
        fifo_in_msg = msg;
        tick;
        chk("resp_rdy", {60'd0, resp_rdy}, 64'd1 << d);
        chk("resp_msg", resp_msg, msg);
        for (int s = 0; s < delay; s++) begin
            resp_ack = wrong & ~(4'd1 << d);
            tick;
            chk("resp_hold", {60'd0, resp_rdy}, 64'd1 << d);
            chk("no_pop", {63'd0, fifo_in_ack}, 64'd0);
        end
        resp_ack = 4'd1 << d;
        tick;
        resp_ack = '0;
        fifo_in_rdy = 1'b0;
        chk("in_ack", {63'd0, fifo_in_ack}, 64'd1);
        chk("resp_clr", {60'd0, resp_rdy}, 64'd0);
        tick;
        chk("in_ack_pulse", {63'd0, fifo_in_ack}, 64'd0);
    endtask

    initial begin
        repeat (2) tick;
        chk("rst_out_rdy", {63'd0, fifo_out_rdy}, 64'd0);
        chk("rst_resp_rdy", {60'd0, resp_rdy}, 64'd0);
        chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
        rst = 1'b0;
        tick;

        // single outbound from requester 2
        req_out_msg[2] = 64'hA5;
        rdy_q = 4'b0100;
        out_txn(0);
        // fairness: all four held, each drops after its ack
        rdy_q = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            req_out_msg[k] = 64'h1000 + 64'(k);
            out_txn(0);
        end
        rdy_q = 4'b0010;
        out_txn(0);
        rdy_q = 4'b0011;
        out_txn(0);
        out_txn(0);
        // FIFO full: eight quick pushes, ninth stalls until a slot frees
        for (int k = 0; k < 9; k++) begin
            rdy_q = 4'd1 << $urandom_range(0, 3);
            req_out_msg[$clog2(int'(rdy_q))] = {$urandom, $urandom};
            out_txn(k == 8 ? 6 : 0);
        end
        // random outbound traffic
        for (int k = 0; k < 30; k++) begin
            logic [3:0] nw;
            nw = 4'($urandom_range(1, 15)) & ~rdy_q;
            for (int j = 0; j < 4; j++) if (nw[j]) req_out_msg[j] = {$urandom, $urandom};
            rdy_q = rdy_q | nw;
            if (rdy_q == 0) rdy_q = 4'b0001;
            out_txn($urandom_range(0, 3));
        end
        rdy_q = '0;
        req_out_rdy = '0;
        tick;

        // inbound routing, wrong-requester ack ignored
        in_txn(64'h8000_0000_0000_0042, 2, 4'b0010);
        resp_ack = 4'b1111;
        tick;
        resp_ack = '0;
        chk("idle_ack_ign", {63'd0, fifo_in_ack}, 64'd0);
        for (int k = 0; k < 12; k++)
            in_txn({$urandom, $urandom}, $urandom_range(0, 3), 4'($urandom));

        // both directions at once
        rdy_q = 4'b1001;
        req_out_msg[0] = 64'hBEEF;
        req_out_msg[3] = 64'hCAFE;
        fork
            out_txn(1);
            in_txn(64'h4000_0000_0000_0007, 1, 4'b1111);
        join
        rdy_q = '0;
        req_out_rdy = '0;

        // 3-requester instance: deliver to 2, then drop destination 3 until saturation
        fifo_in_rdy3 = 1'b1;
        fifo_in_msg3 = 64'h8000_0000_0000_0011;
        tick;
        chk("u3_resp_rdy", {61'd0, resp_rdy3}, 64'd4);
        resp_ack3 = 3'b100;
        tick;
        resp_ack3 = '0;
        chk("u3_in_ack", {63'd0, fifo_in_ack3}, 64'd1);
        fifo_in_msg3 = 64'hC000_0000_0000_0099;
        tick;
        for (int k = 0; k < 260; k++) begin
            tick;
            drops_m = drops_m < 255 ? drops_m + 1 : 255;
            if (k < 2 || k > 252) begin
                chk("drop_ack", {63'd0, fifo_in_ack3}, 64'd1);
                chk("drop_no_resp", {61'd0, resp_rdy3}, 64'd0);
                chk("drop_cnt", {56'd0, drop_cnt3}, 64'(drops_m));
            end
            tick;
            if (k == 0) chk("drop_ack_pulse", {63'd0, fifo_in_ack3}, 64'd0);
        end
        fifo_in_rdy3 = 1'b0;
        tick;

        // async reset with outbound in O_WAIT (rr=3) and inbound in I_DELIVER
        rdy_q = 4'b0100;
        req_out_rdy = rdy_q;
        req_out_msg[2] = 64'h77;
        fifo_in_rdy = 1'b1;
        fifo_in_msg = 64'h4000_0000_0000_0123;
        tick;
        chk("pre_rst_out", {63'd0, fifo_out_rdy}, 64'd1);
        chk("pre_rst_resp", {60'd0, resp_rdy}, 64'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_rdy", {63'd0, fifo_out_rdy}, 64'd0);
        chk("arst_out_msg", fifo_out_msg, 64'd0);
        chk("arst_resp_rdy", {60'd0, resp_rdy}, 64'd0);
        chk("arst_resp_msg", resp_msg, 64'd0);
        chk("arst_drop3", {56'd0, drop_cnt3}, 64'd0);
        rdy_q = '0;
        req_out_rdy = '0;
        fifo_in_rdy = 1'b0;
        tick;
        rst = 1'b0;
        rr_m = 0;
        tick;
        chk("post_rst_idle", {63'd0, fifo_out_rdy}, 64'd0);
        rdy_q = 4'b1111;
        for (int k = 0; k < 4; k++) req_out_msg[k] = {$urandom, $urandom};
        out_txn(0);
        in_txn(64'hC000_0000_0000_0555, 1, 4'b0000);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
